way_replace_ctrl: RTL and testbench

- Per-set replacement controller for the L2 cache data path, and the driver side of the LRU update interface.
- Consumes tag-lookup results and the LRU victim index, and produces the update_entry/update_index stream into the LRU matrix.
- On a miss, selects a victim way, issues a refill request to the memory side, and waits for the refill response.
- Reports completion to the pipeline through a valid/ready handshake.

---
 rtl/way_replace_ctrl_pkg.sv | 14 +
 rtl/way_replace_ctrl_victim_sel.sv | 44 ++++
 rtl/way_replace_ctrl.sv | 110 +++++++++++
 tb/tb_way_replace_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/way_replace_ctrl_pkg.sv
// Shared types and defaults for the L2 way replacement controller.
package way_replace_ctrl_pkg;

  localparam int unsigned DEF_NUM_WAY   = 4;
  localparam int unsigned DEF_WAY_DEPTH = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/way_replace_ctrl_victim_sel.sv
// Victim way selection: lowest-index invalid way, else the LRU way.
module way_replace_ctrl_victim_sel
  import way_replace_ctrl_pkg::*;
#(
  parameter int unsigned NUM_WAY   = DEF_NUM_WAY,
  parameter int unsigned WAY_DEPTH = DEF_WAY_DEPTH
) (
  input  logic [NUM_WAY-1:0]   way_valid_i,
  input  logic [WAY_DEPTH-1:0] lru_index_i,
  output logic [WAY_DEPTH-1:0] victim_o
);

  logic [NUM_WAY-1:0]   invalid;
  logic [NUM_WAY-1:0]   invalid_onehot;
  logic [WAY_DEPTH-1:0] invalid_bin;
  logic                 found;

  assign invalid = ~way_valid_i;

  // Fixed-priority arbiter: index 0 wins.
  always_comb begin
    invalid_onehot = '0;
    found          = 1'b0;
    for (int i = 0; i < NUM_WAY; i++) begin
      if (invalid[i] && !found) begin
        invalid_onehot[i] = 1'b1;
        found             = 1'b1;
      end
    end
  end

  // One-hot to binary.
  always_comb begin
    invalid_bin = '0;
    for (int i = 0; i < NUM_WAY; i++) begin
      if (invalid_onehot[i]) begin
        invalid_bin = invalid_bin | WAY_DEPTH'(i);
      end
    end
  end

  assign victim_o = found ? invalid_bin : lru_index_i;

endmodule

// File: rtl/way_replace_ctrl.sv
// Per-set replacement controller: hit/miss handling, refill handshake, LRU update pulse.
module way_replace_ctrl
  import way_replace_ctrl_pkg::*;
#(
  parameter int unsigned NUM_WAY   = DEF_NUM_WAY,
  parameter int unsigned WAY_DEPTH = DEF_WAY_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lookup_valid_i,
  output logic                 lookup_ready_o,
  input  logic                 lookup_hit_i,
  input  logic [WAY_DEPTH-1:0] lookup_hit_way_i,
  input  logic [NUM_WAY-1:0]   way_valid_i,
  input  logic [WAY_DEPTH-1:0] lru_index_i,
  output logic                 update_entry_o,
  output logic [WAY_DEPTH-1:0] update_index_o,
  output logic                 refill_req_valid_o,
  input  logic                 refill_req_ready_i,
  output logic [WAY_DEPTH-1:0] refill_req_way_o,
  input  logic                 refill_rsp_valid_i,
  output logic                 refill_rsp_ready_o,
  output logic                 done_valid_o,
  input  logic                 done_ready_i,
  output logic                 done_hit_o,
  output logic [WAY_DEPTH-1:0] done_way_o
);

  state_e               state_q, state_d;
  logic [WAY_DEPTH-1:0] way_q, way_d;
  logic                 hit_q, hit_d;
  logic                 upd_q, upd_d;
  logic [WAY_DEPTH-1:0] victim;

  way_replace_ctrl_victim_sel #(
    .NUM_WAY  (NUM_WAY),
    .WAY_DEPTH(WAY_DEPTH)
  ) u_victim_sel (
    .way_valid_i(way_valid_i),
    .lru_index_i(lru_index_i),
    .victim_o   (victim)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      way_q   <= '0;
      hit_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      hit_q   <= hit_d;
      upd_q   <= upd_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    way_d              = way_q;
    hit_d              = hit_q;
    upd_d              = 1'b0;
    lookup_ready_o     = 1'b0;
    refill_req_valid_o = 1'b0;
    refill_rsp_ready_o = 1'b0;
    done_valid_o       = 1'b0;
    update_entry_o     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        lookup_ready_o = 1'b1;
        if (lookup_valid_i) begin
          if (lookup_hit_i) begin
            way_d   = lookup_hit_way_i;
            hit_d   = 1'b1;
            upd_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            way_d   = victim;
            hit_d   = 1'b0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        refill_req_valid_o = 1'b1;
        if (refill_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        refill_rsp_ready_o = 1'b1;
        if (refill_rsp_valid_i) begin
          upd_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_valid_o = 1'b1;
        // upd_q is only set on DONE entry, so a stalled completion pulses once.
        update_entry_o = upd_q;
        if (done_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign update_index_o   = way_q;
  assign refill_req_way_o = way_q;
  assign done_way_o       = way_q;
  assign done_hit_o       = hit_q;

endmodule

// File: tb/tb_way_replace_ctrl.sv
// Directed bench for way_replace_ctrl with a small LRU order model for the closed-loop case.
module tb_way_replace_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       lookup_valid_i;
  logic       lookup_ready_o;
  logic       lookup_hit_i;
  logic [1:0] lookup_hit_way_i;
  logic [3:0] way_valid_i;
  logic [1:0] lru_index_i;
  logic       update_entry_o;
  logic [1:0] update_index_o;
  logic       refill_req_valid_o;
  logic       refill_req_ready_i;
  logic [1:0] refill_req_way_o;
  logic       refill_rsp_valid_i;
  logic       refill_rsp_ready_o;
  logic       done_valid_o;
  logic       done_ready_i;
  logic       done_hit_o;
  logic [1:0] done_way_o;

  int n_vec = 0;
  int n_err = 0;
  int upd_cnt = 0;
  int req_cnt = 0;
  int base;
  int order [4];

  always #5 clk = ~clk;

  way_replace_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .lookup_valid_i    (lookup_valid_i),
    .lookup_ready_o    (lookup_ready_o),
    .lookup_hit_i      (lookup_hit_i),
    .lookup_hit_way_i  (lookup_hit_way_i),
    .way_valid_i       (way_valid_i),
    .lru_index_i       (lru_index_i),
    .update_entry_o    (update_entry_o),
    .update_index_o    (update_index_o),
    .refill_req_valid_o(refill_req_valid_o),
    .refill_req_ready_i(refill_req_ready_i),
    .refill_req_way_o  (refill_req_way_o),
    .refill_rsp_valid_i(refill_rsp_valid_i),
    .refill_rsp_ready_o(refill_rsp_ready_o),
    .done_valid_o      (done_valid_o),
    .done_ready_i      (done_ready_i),
    .done_hit_o        (done_hit_o),
    .done_way_o        (done_way_o)
  );

  always @(posedge clk) begin
    if (update_entry_o) upd_cnt <= upd_cnt + 1;
    if (refill_req_valid_o && refill_req_ready_i) req_cnt <= req_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move a way to the MRU end of the model order; order[0] is the LRU way.
  task automatic touch(input int way);
    int pos;
    pos = 0;
    for (int i = 0; i < 4; i++) if (order[i] == way) pos = i;
    for (int i = pos; i < 3; i++) order[i] = order[i + 1];
    order[3] = way;
  endtask

  task automatic do_hit(input logic [1:0] way);
    lookup_valid_i   = 1'b1;
    lookup_hit_i     = 1'b1;
    lookup_hit_way_i = way;
    done_ready_i     = 1'b1;
    step();
    lookup_valid_i = 1'b0;
    lookup_hit_i   = 1'b0;
    check_eq("loop_upd_entry", 32'(update_entry_o), 32'd1);
    check_eq("loop_upd_index", 32'(update_index_o), 32'(way));
    if (update_entry_o) touch(int'(update_index_o));
    step();
  endtask

  initial begin
    rst                = 1'b1;
    lookup_valid_i     = 1'b0;
    lookup_hit_i       = 1'b0;
    lookup_hit_way_i   = 2'd0;
    way_valid_i        = 4'b0000;
    lru_index_i        = 2'd0;
    refill_req_ready_i = 1'b0;
    refill_rsp_valid_i = 1'b0;
    done_ready_i       = 1'b0;
    step();
    step();
    check_eq("rst_lookup_ready", 32'(lookup_ready_o), 32'd1);
    check_eq("rst_done_valid", 32'(done_valid_o), 32'd0);
    check_eq("rst_req_valid", 32'(refill_req_valid_o), 32'd0);
    check_eq("rst_rsp_ready", 32'(refill_rsp_ready_o), 32'd0);
    check_eq("rst_upd_entry", 32'(update_entry_o), 32'd0);
    check_eq("rst_upd_index", 32'(update_index_o), 32'd0);
    rst = 1'b0;

    // Hit on way 2; hit priority over valid/LRU inputs.
    way_valid_i      = 4'b0000;
    lru_index_i      = 2'd1;
    lookup_valid_i   = 1'b1;
    lookup_hit_i     = 1'b1;
    lookup_hit_way_i = 2'd2;
    done_ready_i     = 1'b1;
    step();
    lookup_valid_i = 1'b0;
    lookup_hit_i   = 1'b0;
    check_eq("hit_upd_entry", 32'(update_entry_o), 32'd1);
    check_eq("hit_upd_index", 32'(update_index_o), 32'd2);
    check_eq("hit_done_valid", 32'(done_valid_o), 32'd1);
    check_eq("hit_done_hit", 32'(done_hit_o), 32'd1);
    check_eq("hit_done_way", 32'(done_way_o), 32'd2);
    check_eq("hit_lookup_ready", 32'(lookup_ready_o), 32'd0);
    step();
    check_eq("hit_idle_ready", 32'(lookup_ready_o), 32'd1);
    check_eq("hit_idle_done", 32'(done_valid_o), 32'd0);

    // Miss, first invalid way is 2; request stalled three cycles.
    base           = req_cnt;
    way_valid_i    = 4'b1011;
    lru_index_i    = 2'd0;
    lookup_valid_i = 1'b1;
    step();
    lookup_valid_i = 1'b0;
    way_valid_i    = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      check_eq("miss_req_valid", 32'(refill_req_valid_o), 32'd1);
      check_eq("miss_req_way", 32'(refill_req_way_o), 32'd2);
      step();
    end
    refill_req_ready_i = 1'b1;
    check_eq("miss_req_valid4", 32'(refill_req_valid_o), 32'd1);
    step();
    refill_req_ready_i = 1'b0;
    check_eq("miss_wait_req", 32'(refill_req_valid_o), 32'd0);
    check_eq("miss_wait_rsp_rdy", 32'(refill_rsp_ready_o), 32'd1);
    check_eq("miss_req_count", 32'(req_cnt - base), 32'd1);
    base = upd_cnt;
    for (int i = 0; i < 4; i++) step();
    refill_rsp_valid_i = 1'b1;
    check_eq("miss_wait_done", 32'(done_valid_o), 32'd0);
    step();
    refill_rsp_valid_i = 1'b0;
    check_eq("miss_done_valid", 32'(done_valid_o), 32'd1);
    check_eq("miss_done_hit", 32'(done_hit_o), 32'd0);
    check_eq("miss_done_way", 32'(done_way_o), 32'd2);
    check_eq("miss_upd_entry", 32'(update_entry_o), 32'd1);
    check_eq("miss_upd_index", 32'(update_index_o), 32'd2);
    step();
    check_eq("miss_upd_count", 32'(upd_cnt - base), 32'd1);
    check_eq("miss_idle_ready", 32'(lookup_ready_o), 32'd1);

    // Full-set miss, victim from LRU; response arrives with REQ, must be ignored.
    done_ready_i   = 1'b0;
    way_valid_i    = 4'b1111;
    lru_index_i    = 2'd3;
    lookup_valid_i = 1'b1;
    step();
    lookup_valid_i     = 1'b0;
    refill_req_ready_i = 1'b1;
    refill_rsp_valid_i = 1'b1;
    check_eq("full_req_way", 32'(refill_req_way_o), 32'd3);
    step();
    refill_req_ready_i = 1'b0;
    check_eq("full_in_wait", 32'(refill_rsp_ready_o), 32'd1);
    check_eq("full_rsp_ignored", 32'(done_valid_o), 32'd0);
    step();
    refill_rsp_valid_i = 1'b0;
    check_eq("full_done_valid", 32'(done_valid_o), 32'd1);
    check_eq("full_done_way", 32'(done_way_o), 32'd3);

    // Stall in DONE for four cycles.
    base = upd_cnt;
    for (int i = 0; i < 4; i++) begin
      check_eq("stall_done_valid", 32'(done_valid_o), 32'd1);
      check_eq("stall_done_way", 32'(done_way_o), 32'd3);
      check_eq("stall_done_hit", 32'(done_hit_o), 32'd0);
      check_eq("stall_lookup_rdy", 32'(lookup_ready_o), 32'd0);
      check_eq("stall_upd_entry", 32'(update_entry_o), (i == 0) ? 32'd1 : 32'd0);
      if (i == 3) done_ready_i = 1'b1;
      step();
    end
    check_eq("stall_upd_count", 32'(upd_cnt - base), 32'd1);
    check_eq("stall_released", 32'(done_valid_o), 32'd0);

    // Reset while waiting for the refill response.
    way_valid_i    = 4'b0111;
    lookup_valid_i = 1'b1;
    step();
    lookup_valid_i     = 1'b0;
    refill_req_ready_i = 1'b1;
    check_eq("rstw_req_way", 32'(refill_req_way_o), 32'd3);
    step();
    refill_req_ready_i = 1'b0;
    check_eq("rstw_in_wait", 32'(refill_rsp_ready_o), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rstw_rsp_ready", 32'(refill_rsp_ready_o), 32'd0);
    check_eq("rstw_done_valid", 32'(done_valid_o), 32'd0);
    check_eq("rstw_lookup_ready", 32'(lookup_ready_o), 32'd1);
    base               = upd_cnt;
    refill_rsp_valid_i = 1'b1;
    step();
    refill_rsp_valid_i = 1'b0;
    step();
    check_eq("rstw_stale_upd", 32'(upd_cnt - base), 32'd0);
    check_eq("rstw_stale_done", 32'(done_valid_o), 32'd0);

    // Closed loop against an LRU order model.
    order[0] = 3;
    order[1] = 2;
    order[2] = 1;
    order[3] = 0;
    for (int w = 0; w < 4; w++) do_hit(2'(w));
    way_valid_i    = 4'b1111;
    lru_index_i    = 2'(order[0]);
    lookup_valid_i = 1'b1;
    step();
    lookup_valid_i = 1'b0;
    check_eq("loop_victim", 32'(refill_req_way_o), 32'd0);
    check_eq("loop_req_valid", 32'(refill_req_valid_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
